serial_bus_arbiter: RTL and testbench

Shares the single serial data path between up to NUM_MASTERS requesting masters. The slave-side output port drives that path and signals transfer completion with tx_done. The arbiter grants exactly one master at a time, using round-robin order. It holds the grant until the slave reports tx_done, the master withdraws its request, or (optionally) a watchdog expires. It sits between the master request lines and the bus mux select.

---
 rtl/serial_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_bus_arbiter
// Purpose  : Round-robin arbiter giving one master at a time the shared serial
//            data path. A grant is held until the slave pulses tx_done, the
//            master drops its request, or the optional watchdog expires.
//            A single RELEASE turnaround cycle follows every grant.
// Options  : `define ARB_TIMEOUT_EN turns on the BUSY watchdog and the
//            timeout_err pulse. Without it, a grant is held indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module serial_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   tx_done,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [ID_W-1:0]        grant_id,
  output logic                   bus_busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // After reset the pointer names the last master, so master 0 wins first.
  localparam logic [ID_W-1:0] c_LAST_RST = ID_W'(NUM_MASTERS - 1);

  // Reject configurations the index logic cannot represent.
  if ((ID_W < $clog2(NUM_MASTERS)) || (NUM_MASTERS < 2) || (NUM_MASTERS > 8) ||
      (TIMEOUT_CYCLES < 2)) begin : g_param_check
    $error("serial_bus_arbiter: illegal parameter combination");
  end

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [NUM_MASTERS-1:0]   r_grant;
  logic [NUM_MASTERS-1:0]   w_grant_nxt;
  logic [ID_W-1:0]          r_grant_id;
  logic [ID_W-1:0]          w_id_nxt;
  logic [ID_W-1:0]          r_last;
  logic [ID_W-1:0]          w_last_nxt;
  logic                     w_sel_found;
  logic [ID_W-1:0]          w_sel_id;
  logic                     w_req_held;
  logic                     w_exit;
  logic                     w_expire;
  logic                     w_timeout_nxt;

  // The granted master still requests when its request bit overlaps the grant.
  assign w_req_held = |(req & r_grant);

  // A watchdog release only counts as an error if nothing else ended the grant.
  assign w_timeout_nxt = w_expire && !tx_done && w_req_held;

  assign w_exit = (r_state == ST_BUSY) && (tx_done || !w_req_held || w_expire);

`ifdef ARB_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_timeout_err;

  assign w_expire = (r_state == ST_BUSY) && (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

  // Count BUSY cycles of the current grant; restart from zero on every exit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if ((r_state == ST_BUSY) && !w_exit) begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // One-cycle error pulse, aligned with the grant falling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout_nxt;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_expire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Round-robin search: first requester above the last winner, then wrap.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_id    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!w_sel_found && req[i] && (i > int'(r_last))) begin
        w_sel_found = 1'b1;
        w_sel_id    = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!w_sel_found && req[i] && (i <= int'(r_last))) begin
        w_sel_found = 1'b1;
        w_sel_id    = ID_W'(i);
      end
    end
  end

  // Next-state and next-output logic for IDLE -> BUSY -> RELEASE.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_id_nxt    = r_grant_id;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        if (w_sel_found) begin
          w_grant_nxt = NUM_MASTERS'(1) << w_sel_id;
          w_id_nxt    = w_sel_id;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_exit) begin
          w_grant_nxt = '0;
          w_last_nxt  = r_grant_id;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, grant and fairness pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_last     <= c_LAST_RST;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_id_nxt;
      r_last     <= w_last_nxt;
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign bus_busy = |r_grant;

endmodule
`default_nettype wire

// File: tb/tb_serial_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_bus_arbiter
// Purpose  : Directed self-checking bench for serial_bus_arbiter: a vector
//            table for round-robin ordering plus hand sequences for long
//            transfers, completion/abort races, watchdog and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       tx_done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       bus_busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic       tx;
    logic [3:0] grant;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[17];

  serial_bus_arbiter #(
    .NUM_MASTERS    (4),
    .ID_W           (2),
    .TIMEOUT_CYCLES (64)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .tx_done     (tx_done),
    .grant       (grant),
    .grant_id    (grant_id),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against one expected grant; grant_id only while busy.
  task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] id,
                            input logic terr);
    chk({name, ".grant"}, 32'(grant), 32'(g));
    chk({name, ".busy"}, 32'(bus_busy), 32'(g != 4'b0000));
    chk({name, ".terr"}, 32'(timeout_err), 32'(terr));
    if (g != 4'b0000) chk({name, ".id"}, 32'(grant_id), 32'(id));
  endtask

  // Drive inputs, take one rising edge, and settle 1 time unit past it.
  task automatic cyc(input logic [3:0] r, input logic t);
    req     = r;
    tx_done = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // All-request round robin from reset: 0,1,2,3,0 with one RELEASE cycle between.
    vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0000, 2'd0};
    vecs[2]  = '{4'b1111, 1'b0, 4'b0000, 2'd0};
    vecs[3]  = '{4'b1111, 1'b0, 4'b0010, 2'd1};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0000, 2'd0};
    vecs[5]  = '{4'b1111, 1'b0, 4'b0000, 2'd0};
    vecs[6]  = '{4'b1111, 1'b0, 4'b0100, 2'd2};
    vecs[7]  = '{4'b1111, 1'b1, 4'b0000, 2'd0};
    vecs[8]  = '{4'b1111, 1'b0, 4'b0000, 2'd0};
    vecs[9]  = '{4'b1111, 1'b0, 4'b1000, 2'd3};
    vecs[10] = '{4'b1111, 1'b1, 4'b0000, 2'd0};
    vecs[11] = '{4'b1111, 1'b0, 4'b0000, 2'd0};
    vecs[12] = '{4'b1111, 1'b0, 4'b0001, 2'd0};
    vecs[13] = '{4'b1111, 1'b1, 4'b0000, 2'd0};
    vecs[14] = '{4'b0000, 1'b0, 4'b0000, 2'd0};
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 2'd0};  // tx_done in IDLE is ignored
    vecs[16] = '{4'b0100, 1'b0, 4'b0100, 2'd2};  // single requester, pointer at 0

    reset   = 1'b0;
    req     = 4'b1111;
    tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 4'b0000, 2'd0, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].req, vecs[i].tx);
      expect_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].id, 1'b0);
    end

    // Long transfer for master 2, completion on the ninth cycle of BUSY.
    for (int i = 0; i < 8; i++) begin
      cyc(4'b0100, 1'b0);
      expect_out("m2_hold", 4'b0100, 2'd2, 1'b0);
    end
    cyc(4'b0100, 1'b1);
    expect_out("m2_done", 4'b0000, 2'd0, 1'b0);
    cyc(4'b0000, 1'b0);
    expect_out("m2_release", 4'b0000, 2'd0, 1'b0);
    cyc(4'b0000, 1'b0);
    expect_out("m2_idle", 4'b0000, 2'd0, 1'b0);

    // Move the pointer to 0, then let master 1 finish while dropping its request.
    cyc(4'b0001, 1'b0);
    expect_out("m0_grant", 4'b0001, 2'd0, 1'b0);
    cyc(4'b0001, 1'b1);
    expect_out("m0_done", 4'b0000, 2'd0, 1'b0);
    cyc(4'b1010, 1'b0);
    expect_out("m1_release", 4'b0000, 2'd0, 1'b0);
    cyc(4'b1010, 1'b0);
    expect_out("m1_grant", 4'b0010, 2'd1, 1'b0);
    cyc(4'b1000, 1'b1);
    expect_out("m1_done_drop", 4'b0000, 2'd0, 1'b0);
    cyc(4'b1000, 1'b0);
    expect_out("m1_turnaround", 4'b0000, 2'd0, 1'b0);
    cyc(4'b1000, 1'b0);
    expect_out("m3_grant", 4'b1000, 2'd3, 1'b0);

    // Master 3 aborts by dropping its request with no tx_done.
    cyc(4'b0000, 1'b0);
    expect_out("m3_abort", 4'b0000, 2'd0, 1'b0);
    cyc(4'b0000, 1'b0);
    expect_out("m3_release", 4'b0000, 2'd0, 1'b0);

    // Master 0 requests and never sees tx_done.
    cyc(4'b0001, 1'b0);
    expect_out("wd_grant", 4'b0001, 2'd0, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 63; i++) begin
      cyc(4'b0001, 1'b0);
      expect_out("wd_hold", 4'b0001, 2'd0, 1'b0);
    end
    cyc(4'b0001, 1'b0);
    expect_out("wd_expire", 4'b0000, 2'd0, 1'b1);
    cyc(4'b0001, 1'b0);
    expect_out("wd_release", 4'b0000, 2'd0, 1'b0);
    cyc(4'b0001, 1'b0);
    expect_out("wd_regrant", 4'b0001, 2'd0, 1'b0);
`else
    for (int i = 0; i < 199; i++) begin
      cyc(4'b0001, 1'b0);
      expect_out("hold200", 4'b0001, 2'd0, 1'b0);
    end
`endif
    cyc(4'b0001, 1'b1);
    expect_out("wd_done", 4'b0000, 2'd0, 1'b0);
    cyc(4'b0000, 1'b0);
    expect_out("wd_idle", 4'b0000, 2'd0, 1'b0);

    // Pointer is 0 here; grant master 3, then reset in mid-cycle.
    cyc(4'b1000, 1'b0);
    expect_out("rst_m3_grant", 4'b1000, 2'd3, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    expect_out("rst_async_drop", 4'b0000, 2'd0, 1'b0);
    req = 4'b1001;
    @(posedge clk);
    #1;
    expect_out("rst_held", 4'b0000, 2'd0, 1'b0);
    reset = 1'b1;
    cyc(4'b1001, 1'b0);
    expect_out("rst_ptr_restored", 4'b0001, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
